dsi_pixel_framer: RTL and testbench

Downstream neighbour of the video mixer. Consumes the mixer's 48-bit double-pixel write stream plus vsync and drives the frame handshake back to it. Cuts the stream into lines and frames of fixed geometry and buffers it in a FIFO. Presents flagged words (SOF/SOL/EOL/EOF) to the DSI packet engine over a valid/ready interface.

---
 rtl/dsi_pixel_framer_pkg.sv | 34 +++
 rtl/dsi_pixel_framer_fifo.sv | 66 ++++++
 rtl/dsi_pixel_framer.sv | 170 +++++++++++++++++
 tb/tb_dsi_pixel_framer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsi_pixel_framer_pkg.sv
// Shared definitions for the DSI pixel framer: FSM states, FIFO word layout,
// error bit positions and the word packing helper.
package dsi_pixel_framer_pkg;

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam int C_PIX_W  = 48;
  localparam int C_WORD_W = 52;
  localparam int C_CNT_W  = 11;

  // FIFO word = {eof, eol, sol, sof, pix[47:0]}
  localparam int C_FLAG_SOF = 48;
  localparam int C_FLAG_SOL = 49;
  localparam int C_FLAG_EOL = 50;
  localparam int C_FLAG_EOF = 51;

  localparam int C_ERR_OVF   = 0;
  localparam int C_ERR_SHORT = 1;

  function automatic logic [C_WORD_W-1:0] pack_word(
    input logic [C_PIX_W-1:0] pix,
    input logic               sof,
    input logic               sol,
    input logic               eol,
    input logic               eof
  );
    return {eof, eol, sol, sof, pix};
  endfunction

endpackage

// File: rtl/dsi_pixel_framer_fifo.sv
// Generic synchronous FIFO with show-ahead read data and an occupancy count.
// Writes are refused when full unless a read frees a slot in the same cycle.
module dsi_pixel_framer_fifo #(
  parameter int g_data_width = 52,
  parameter int g_size       = 256,
  parameter int g_count_w    = $clog2(g_size + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    we_i,
  input  logic [g_data_width-1:0] d_i,
  input  logic                    rd_i,
  output logic [g_data_width-1:0] q_o,
  output logic                    empty_o,
  output logic [g_count_w-1:0]    count_o
);

  localparam int C_AW = (g_size > 1) ? $clog2(g_size) : 1;

  logic [g_data_width-1:0] r_mem [g_size];
  logic [C_AW-1:0]         r_wr_ptr;
  logic [C_AW-1:0]         r_rd_ptr;
  logic [g_count_w-1:0]    r_count;
  logic                    w_full;
  logic                    w_do_rd;
  logic                    w_do_wr;

  // Pointers wrap explicitly so non power-of-two depths work.
  function automatic logic [C_AW-1:0] ptr_inc(input logic [C_AW-1:0] p);
    return (p == C_AW'(g_size - 1)) ? '0 : p + C_AW'(1);
  endfunction

  assign empty_o = (r_count == '0);
  assign w_full  = (r_count == g_count_w'(g_size));
  assign w_do_rd = rd_i && !empty_o;
  assign w_do_wr = we_i && (!w_full || w_do_rd);
  assign q_o     = r_mem[r_rd_ptr];
  assign count_o = r_count;

  always_ff @(posedge clk_i) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_do_rd) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_do_wr && !w_do_rd) begin
        r_count <= r_count + g_count_w'(1);
      end else if (!w_do_wr && w_do_rd) begin
        r_count <= r_count - g_count_w'(1);
      end
    end
  end

endmodule

// File: rtl/dsi_pixel_framer.sv
// Cuts the mixer's double-pixel stream into flagged lines and frames, buffers it,
// and presents it to the DSI packet engine through a first-word-fall-through register.
module dsi_pixel_framer
  import dsi_pixel_framer_pkg::*;
#(
  parameter int g_h_active              = 320,
  parameter int g_v_active              = 480,
  parameter int g_fifo_size             = 256,
  parameter int g_almost_full_threshold = 240
) (
  input  logic               clk_sys_i,
  input  logic               rst_n_i,
  input  logic               pix_wr_i,
  input  logic [C_PIX_W-1:0] pix_i,
  input  logic               vsync_i,
  output logic               almost_full_o,
  output logic               next_frame_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [C_PIX_W-1:0] out_pix_o,
  output logic               out_sof_o,
  output logic               out_sol_o,
  output logic               out_eol_o,
  output logic               out_eof_o,
  output logic [1:0]         err_o
);

  localparam int C_WPL   = g_h_active / 2;
  localparam int C_OCC_W = $clog2(g_fifo_size + 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [C_CNT_W-1:0]    r_x;
  logic [C_CNT_W-1:0]    r_y;
  logic [C_WORD_W-1:0]   r_out_word;
  logic                  r_out_valid;
  logic                  r_almost_full;
  logic [1:0]            r_err;
  logic [1:0]            w_err;

  logic                  w_is_sol;
  logic                  w_is_sof;
  logic                  w_is_eol;
  logic                  w_is_eof;
  logic                  w_active_wr;
  logic                  w_out_take;
  logic                  w_full;
  logic                  w_fifo_we;
  logic                  w_load;
  logic                  w_drop;
  logic                  w_short;
  logic [C_WORD_W-1:0]   w_fifo_d;
  logic [C_WORD_W-1:0]   w_fifo_q;
  logic                  w_fifo_empty;
  logic [C_OCC_W-1:0]    w_fifo_count;
  logic [C_OCC_W-1:0]    w_occ;

  assign w_is_sol    = (r_x == '0);
  assign w_is_sof    = w_is_sol && (r_y == '0);
  assign w_is_eol    = (r_x == C_CNT_W'(C_WPL - 1));
  assign w_is_eof    = w_is_eol && (r_y == C_CNT_W'(g_v_active - 1));
  assign w_active_wr = pix_wr_i && (r_state == ST_ACTIVE);
  assign w_out_take  = r_out_valid && out_ready_i;

  // Occupancy includes the output register so total storage equals g_fifo_size.
  assign w_occ     = w_fifo_count + C_OCC_W'(r_out_valid);
  assign w_full    = (w_occ >= C_OCC_W'(g_fifo_size));
  assign w_fifo_we = w_active_wr && (!w_full || w_out_take);
  assign w_load    = !w_fifo_empty && (!r_out_valid || out_ready_i);
  assign w_drop    = pix_wr_i && ((r_state != ST_ACTIVE) || (w_full && !w_out_take));
  assign w_short   = (r_state == ST_ACTIVE) && vsync_i && !(pix_wr_i && w_is_eof);
  assign w_fifo_d  = pack_word(pix_i, w_is_sof, w_is_sol, w_is_eol, w_is_eof);

  dsi_pixel_framer_fifo #(
    .g_data_width (C_WORD_W),
    .g_size       (g_fifo_size),
    .g_count_w    (C_OCC_W)
  ) u_fifo (
    .clk_i   (clk_sys_i),
    .rst_n_i (rst_n_i),
    .we_i    (w_fifo_we),
    .d_i     (w_fifo_d),
    .rd_i    (w_load),
    .q_o     (w_fifo_q),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  // A completed eof word takes priority over a coincident vsync.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_REQ: begin
        if (vsync_i) w_state_next = ST_SYNC;
      end
      ST_SYNC: begin
        if (!vsync_i) w_state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (pix_wr_i && w_is_eof) begin
          w_state_next = ST_REQ;
        end else if (vsync_i) begin
          w_state_next = ST_SYNC;
        end
      end
      default: w_state_next = ST_REQ;
    endcase
  end

  always_comb begin
    w_err              = '0;
    w_err[C_ERR_OVF]   = w_drop;
    w_err[C_ERR_SHORT] = w_short;
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_REQ;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Dropped words on a full buffer still advance x/y to keep geometry aligned.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_x <= '0;
      r_y <= '0;
    end else if ((r_state == ST_SYNC) && !vsync_i) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_active_wr) begin
      if (w_is_eol) begin
        r_x <= '0;
        r_y <= w_is_eof ? '0 : r_y + C_CNT_W'(1);
      end else begin
        r_x <= r_x + C_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_out_word    <= '0;
      r_out_valid   <= 1'b0;
      r_almost_full <= 1'b0;
      r_err         <= '0;
    end else begin
      if (w_load) begin
        r_out_word  <= w_fifo_q;
        r_out_valid <= 1'b1;
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
      r_almost_full <= (w_occ >= C_OCC_W'(g_almost_full_threshold));
      r_err         <= w_err;
    end
  end

  assign next_frame_o  = (r_state == ST_REQ);
  assign almost_full_o = r_almost_full;
  assign out_valid_o   = r_out_valid;
  assign out_pix_o     = r_out_word[C_PIX_W-1:0];
  assign out_sof_o     = r_out_word[C_FLAG_SOF];
  assign out_sol_o     = r_out_word[C_FLAG_SOL];
  assign out_eol_o     = r_out_word[C_FLAG_EOL];
  assign out_eof_o     = r_out_word[C_FLAG_EOF];
  assign err_o         = r_err;

endmodule

// File: tb/tb_dsi_pixel_framer.sv
// Self-checking bench for dsi_pixel_framer on an 8x2 frame with a 16-word buffer;
// a queue scoreboard checks every accepted output word and its flags.
module tb_dsi_pixel_framer;

  localparam int H   = 8;
  localparam int V   = 2;
  localparam int FS  = 16;
  localparam int THR = 12;

  typedef struct {
    logic [47:0] pix;
    logic [3:0]  fl;   // {eof, eol, sol, sof}
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_wr = 1'b0;
  logic [47:0] pix = '0;
  logic        vsync = 1'b0;
  logic        out_ready = 1'b0;
  logic        af, nf, out_valid, sof, sol, eol, eof;
  logic [47:0] out_pix;
  logic [1:0]  err;

  int n_checks = 0;
  int n_pass = 0;
  int ovf_cnt = 0;
  int short_cnt = 0;
  int out_cnt = 0;
  int valid_cycles = 0;
  int hold_bad = 0;
  bit hold_en = 1'b0;
  logic [47:0] hold_word = '0;
  logic [51:0] sb_q[$];
  vec_t tbl[8];

  dsi_pixel_framer #(
    .g_h_active              (H),
    .g_v_active              (V),
    .g_fifo_size             (FS),
    .g_almost_full_threshold (THR)
  ) dut (
    .clk_sys_i     (clk),
    .rst_n_i       (rst_n),
    .pix_wr_i      (pix_wr),
    .pix_i         (pix),
    .vsync_i       (vsync),
    .almost_full_o (af),
    .next_frame_o  (nf),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_pix_o     (out_pix),
    .out_sof_o     (sof),
    .out_sol_o     (sol),
    .out_eol_o     (eol),
    .out_eof_o     (eof),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
  endtask

  always @(negedge clk) begin : mon
    logic [51:0] e;
    if (rst_n) begin
      if (err[0]) ovf_cnt++;
      if (err[1]) short_cnt++;
      if (out_valid) valid_cycles++;
      if (hold_en && out_valid && out_pix !== hold_word) hold_bad++;
      if (out_valid && out_ready) begin
        out_cnt++;
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: got word 0x%0h, want no output", {eof, eol, sol, sof, out_pix});
        end else begin
          e = sb_q.pop_front();
          check("sb_word", {eof, eol, sol, sof, out_pix}, e);
          $display("out word %0d: pix=0x%0h flags(eof,eol,sol,sof)=%b%b%b%b", out_cnt, out_pix, eof, eol, sol, sof);
        end
      end
    end
  end

  task automatic wr(input logic [47:0] p, input logic [3:0] fl, input bit acc);
    @(posedge clk); #1;
    pix_wr = 1'b1;
    pix = p;
    if (acc) sb_q.push_back({fl, p});
  endtask

  task automatic idle();
    @(posedge clk); #1;
    pix_wr = 1'b0;
  endtask

  task automatic sync();
    @(posedge clk); #1;
    vsync = 1'b1;
    @(posedge clk); #1;
    vsync = 1'b0;
  endtask

  task automatic drain(input string name);
    int c = 0;
    while (sb_q.size() != 0 && c < 200) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(name, sb_q.size(), 0);
  endtask

  initial begin : wdog
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int o0, c0, s0, v0;
    logic [47:0] rp;
    for (int i = 0; i < 8; i++) tbl[i] = '{pix: 48'(i), fl: 4'b0000};
    tbl[0].fl = 4'b0011;
    tbl[3].fl = 4'b0100;
    tbl[4].fl = 4'b0010;
    tbl[7].fl = 4'b1100;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_next_frame", nf, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_af", af, 0);
    check("rst_err", err, 0);
    check("rst_out_pix", out_pix, 0);
    check("rst_flags", {eof, eol, sol, sof}, 0);
    rst_n = 1'b1;

    // Full frame with ready held high
    out_ready = 1'b1;
    c0 = out_cnt;
    sync();
    for (int i = 0; i < 8; i++) begin
      wr(48'h10_0000 + tbl[i].pix, tbl[i].fl, 1'b1);
      if (i == 1) begin
        check("lat_n_plus_1", out_valid, 0);
        check("active_next_frame", nf, 0);
      end
      if (i == 2) check("lat_n_plus_2", out_valid, 1);
    end
    idle();
    check("req_after_eof", nf, 1);
    drain("t1_drain");
    check("t1_out_count", out_cnt - c0, 8);

    // Writes in ST_REQ are dropped
    o0 = ovf_cnt;
    v0 = valid_cycles;
    for (int i = 0; i < 3; i++) wr(48'h20_0000 + 48'(i), 4'b0000, 1'b0);
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("req_drop_ovf", ovf_cnt - o0, 3);
    check("req_drop_no_valid", valid_cycles - v0, 0);

    // Fill with ready low: two frames fill the buffer, next 4 words overflow
    out_ready = 1'b0;
    hold_word = 48'hA0_0000;
    hold_en = 1'b1;
    o0 = ovf_cnt;
    c0 = out_cnt;
    sync();
    for (int i = 0; i < 8; i++) wr(48'hA0_0000 + tbl[i].pix, tbl[i].fl, 1'b1);
    idle();
    sync();
    for (int i = 0; i < 8; i++) begin
      wr(48'hA0_0008 + tbl[i].pix, tbl[i].fl, 1'b1);
      if (i == 4) check("af_low_after_12th", af, 0);
      if (i == 5) check("af_high_after_12th", af, 1);
    end
    idle();
    sync();
    for (int i = 0; i < 4; i++) wr(48'hA0_0010 + tbl[i].pix, tbl[i].fl, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("full_ovf_pulses", ovf_cnt - o0, 4);
    check("full_af", af, 1);
    check("full_out_valid", out_valid, 1);
    check("full_out_pix", out_pix, 48'hA0_0000);
    check("full_hold_stable", hold_bad, 0);
    hold_en = 1'b0;
    out_ready = 1'b1;
    drain("full_drain");
    check("full_out_count", out_cnt - c0, 16);
    check("af_deassert", af, 0);
    // Dropped words still advanced x/y: the rest of the frame is line 1
    for (int i = 4; i < 8; i++) wr(48'hA0_0010 + tbl[i].pix, tbl[i].fl, 1'b1);
    idle();
    check("aligned_eof_req", nf, 1);
    drain("aligned_drain");

    // Short frame
    s0 = short_cnt;
    o0 = ovf_cnt;
    c0 = out_cnt;
    sync();
    for (int i = 0; i < 5; i++) wr(48'hB0_0000 + tbl[i].pix, tbl[i].fl, 1'b1);
    idle();
    sync();
    check("short_to_sync", nf, 0);
    for (int i = 0; i < 8; i++) wr(48'hB1_0000 + tbl[i].pix, tbl[i].fl, 1'b1);
    idle();
    drain("short_drain");
    check("short_pulses", short_cnt - s0, 1);
    check("short_no_ovf", ovf_cnt - o0, 0);
    check("short_out_count", out_cnt - c0, 13);

    // Asynchronous reset with 6 words buffered
    out_ready = 1'b0;
    sync();
    for (int i = 0; i < 6; i++) wr(48'hC0_0000 + tbl[i].pix, tbl[i].fl, 1'b0);
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_next_frame", nf, 1);
    check("arst_out_pix", out_pix, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    sync();
    for (int i = 0; i < 8; i++) wr(48'hC1_0000 + tbl[i].pix, tbl[i].fl, 1'b1);
    idle();
    drain("post_rst_drain");

    // Alternating back-pressure across a full frame
    c0 = out_cnt;
    sync();
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          rp = 48'({$urandom(), $urandom()});
          wr(rp, tbl[i].fl, 1'b1);
        end
        idle();
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(posedge clk); #1;
          out_ready = c[0];
        end
      end
    join
    out_ready = 1'b1;
    drain("toggle_drain");
    check("toggle_out_count", out_cnt - c0, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
